// File: rtl/elevator_scheduler_if.sv
// Signal bundle between the button/sensor front end and the elevator scheduler.
// master drives buttons, sensors and tick; slave (the scheduler) drives motor, door and display.
interface elevator_scheduler_if;
  logic       tick;
  logic [3:0] req_in;
  logic [3:0] req_out;
  logic [3:0] sns;
  logic       motor_up;
  logic       motor_dn;
  logic       door_open;
  logic [2:0] story;
  logic [3:0] pending;
  logic [1:0] state_dbg;

  // Inputs are sampled on the scheduler clock and need no handshake.
  // Each req bit is a one-clk pulse, and tick is a one-clk strobe.
  // Outputs are registered and hold until the next state change.
  modport master (
    output tick, req_in, req_out, sns,
    input  motor_up, motor_dn, door_open, story, pending, state_dbg
  );

  modport slave (
    input  tick, req_in, req_out, sns,
    output motor_up, motor_dn, door_open, story, pending, state_dbg
  );
endinterface

// File: rtl/elevator_scheduler.sv
// SCAN-style request scheduler for a 4-floor elevator: latches requests, tracks the floor,
// drives the motor and a timed door. The FSM state is exposed on state_dbg.
module elevator_scheduler #(
  parameter int         N_FLOORS   = 4,
  parameter logic [7:0] DOOR_TICKS = 8'd48
) (
  input logic            clk,
  input logic            rst_n,
  elevator_scheduler_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MOVE_UP   = 2'd1,
    MOVE_DN   = 2'd2,
    DOOR_OPEN = 2'd3
  } state_e;

  state_e     state;
  logic       motor_up_q;
  logic       motor_dn_q;
  logic       door_open_q;
  logic [2:0] story_q;
  logic [3:0] pending_q;
  logic       dir_up;
  logic [7:0] door_cnt;
  logic [1:0] depart_idx;

  logic [1:0] story_idx;
  logic       sns_oh;
  logic [1:0] sns_idx;
  logic [3:0] req_any;
  logic [3:0] above;
  logic [3:0] below;
  logic       arrived;
  logic       open_now;
  logic [1:0] open_idx;
  logic [3:0] set_mask;
  logic [3:0] clr_mask;

  assign req_any = bus.req_in | bus.req_out;

  always_comb begin
    story_idx = 2'd0;
    case (story_q)
      3'd2:    story_idx = 2'd1;
      3'd3:    story_idx = 2'd2;
      3'd4:    story_idx = 2'd3;
      default: story_idx = 2'd0;
    endcase
  end

  // Only a clean one-hot reading is trusted; gaps and multi-hot faults are ignored.
  always_comb begin
    sns_oh  = 1'b1;
    sns_idx = 2'd0;
    case (bus.sns)
      4'b0001: sns_idx = 2'd0;
      4'b0010: sns_idx = 2'd1;
      4'b0100: sns_idx = 2'd2;
      4'b1000: sns_idx = 2'd3;
      default: sns_oh  = 1'b0;
    endcase
  end

  always_comb begin
    above = 4'b0000;
    below = 4'b0000;
    for (int f = 0; f < N_FLOORS; f++) begin
      above[f] = pending_q[f] && (f > int'(story_idx));
      below[f] = pending_q[f] && (f < int'(story_idx));
    end
  end

  assign arrived = sns_oh && (sns_idx != depart_idx);

  // Decide whether the door opens this clk, and at which floor, so the pending bit can be cleared on entry.
  always_comb begin
    open_now = 1'b0;
    open_idx = story_idx;
    case (state)
      IDLE: open_now = pending_q[story_idx];
      MOVE_UP, MOVE_DN: begin
        if (arrived && pending_q[sns_idx]) begin
          open_now = 1'b1;
          open_idx = sns_idx;
        end
      end
      default: open_now = 1'b0;
    endcase
  end

  // While the door is open, a press for this floor only extends the door time.
  always_comb begin
    set_mask = req_any;
    if (state == DOOR_OPEN) set_mask[story_idx] = 1'b0;
    clr_mask = open_now ? (4'b0001 << open_idx) : 4'b0000;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      motor_up_q  <= 1'b0;
      motor_dn_q  <= 1'b0;
      door_open_q <= 1'b0;
      story_q     <= 3'd1;
      pending_q   <= 4'b0000;
      dir_up      <= 1'b1;
      door_cnt    <= 8'd0;
      depart_idx  <= 2'd0;
    end else begin
      if (sns_oh) story_q <= {1'b0, sns_idx} + 3'd1;
      pending_q <= (pending_q & ~clr_mask) | set_mask;

      case (state)
        IDLE: begin
          if (open_now) begin
            state       <= DOOR_OPEN;
            door_open_q <= 1'b1;
            door_cnt    <= 8'd0;
          end else if (dir_up && (above != 4'b0000)) begin
            state      <= MOVE_UP;
            motor_up_q <= 1'b1;
            depart_idx <= story_idx;
          end else if (below != 4'b0000) begin
            state      <= MOVE_DN;
            motor_dn_q <= 1'b1;
            dir_up     <= 1'b0;
            depart_idx <= story_idx;
          end else if (above != 4'b0000) begin
            state      <= MOVE_UP;
            motor_up_q <= 1'b1;
            dir_up     <= 1'b1;
            depart_idx <= story_idx;
          end
        end

        MOVE_UP: begin
          if (open_now) begin
            state       <= DOOR_OPEN;
            motor_up_q  <= 1'b0;
            door_open_q <= 1'b1;
            door_cnt    <= 8'd0;
          end else if (arrived && (sns_idx == 2'd3)) begin
            state      <= IDLE;
            motor_up_q <= 1'b0;
          end
        end

        MOVE_DN: begin
          if (open_now) begin
            state       <= DOOR_OPEN;
            motor_dn_q  <= 1'b0;
            door_open_q <= 1'b1;
            door_cnt    <= 8'd0;
          end else if (arrived && (sns_idx == 2'd0)) begin
            state      <= IDLE;
            motor_dn_q <= 1'b0;
          end
        end

        DOOR_OPEN: begin
          if (req_any[story_idx]) begin
            door_cnt <= 8'd0;
          end else if (bus.tick) begin
            if (door_cnt == DOOR_TICKS - 8'd1) begin
              state       <= IDLE;
              door_open_q <= 1'b0;
              door_cnt    <= 8'd0;
            end else begin
              door_cnt <= door_cnt + 8'd1;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.motor_up  = motor_up_q;
  assign bus.motor_dn  = motor_dn_q;
  assign bus.door_open = door_open_q;
  assign bus.story     = story_q;
  assign bus.pending   = pending_q;
  assign bus.state_dbg = state;

endmodule

// File: tb/tb_elevator_scheduler.sv
// Directed-vector bench for elevator_scheduler: each task drives one scenario and
// compares outputs against hand-computed values at the falling clock edge.
module tb_elevator_scheduler;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_UP   = 2'd1;
  localparam logic [1:0] S_DN   = 2'd2;
  localparam logic [1:0] S_DOOR = 2'd3;

  logic clk;
  logic rst_n;
  int   tests_run;
  int   tests_failed;

  elevator_scheduler_if bus ();

  elevator_scheduler #(.N_FLOORS(4), .DOOR_TICKS(8'd48)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // Clock and reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // Driver tasks
  task automatic do_reset(input logic [3:0] sns_val);
    rst_n       = 1'b0;
    bus.tick    = 1'b0;
    bus.req_in  = 4'b0000;
    bus.req_out = 4'b0000;
    bus.sns     = sns_val;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic pulse_req(input logic [3:0] rin, input logic [3:0] rout);
    bus.req_in  = rin;
    bus.req_out = rout;
    @(negedge clk);
    bus.req_in  = 4'b0000;
    bus.req_out = 4'b0000;
  endtask

  task automatic set_sns(input logic [3:0] s);
    bus.sns = s;
    @(negedge clk);
  endtask

  // Returns at the falling edge right after the clk that sampled the last tick.
  task automatic run_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      if (i > 0) @(negedge clk);
      bus.tick = 1'b1;
      @(negedge clk);
      bus.tick = 1'b0;
    end
  endtask

  // Scenarios
  task automatic test_reset;
    rst_n       = 1'b0;
    bus.tick    = 1'b0;
    bus.req_in  = 4'b0000;
    bus.req_out = 4'b0000;
    bus.sns     = 4'b0001;
    repeat (2) @(negedge clk);
    tests_run++; if (bus.motor_up !== 1'b0) begin tests_failed++; $display("FAIL reset_motor_up got=%b exp=0", bus.motor_up); end
    tests_run++; if (bus.motor_dn !== 1'b0) begin tests_failed++; $display("FAIL reset_motor_dn got=%b exp=0", bus.motor_dn); end
    tests_run++; if (bus.door_open !== 1'b0) begin tests_failed++; $display("FAIL reset_door got=%b exp=0", bus.door_open); end
    tests_run++; if (bus.story !== 3'd1) begin tests_failed++; $display("FAIL reset_story got=%0d exp=1", bus.story); end
    tests_run++; if (bus.pending !== 4'b0000) begin tests_failed++; $display("FAIL reset_pending got=%b exp=0000", bus.pending); end
    tests_run++; if (bus.state_dbg !== S_IDLE) begin tests_failed++; $display("FAIL reset_state got=%0d exp=%0d", bus.state_dbg, S_IDLE); end
    rst_n = 1'b1;
    @(negedge clk);
    set_sns(4'b0100);
    tests_run++; if (bus.story !== 3'd3) begin tests_failed++; $display("FAIL track_story got=%0d exp=3", bus.story); end
    set_sns(4'b0000);
    tests_run++; if (bus.story !== 3'd3) begin tests_failed++; $display("FAIL track_gap_hold got=%0d exp=3", bus.story); end
    set_sns(4'b0110);
    tests_run++; if (bus.story !== 3'd3) begin tests_failed++; $display("FAIL track_multihot_hold got=%0d exp=3", bus.story); end
  endtask

  task automatic test_single_trip;
    do_reset(4'b0001);
    pulse_req(4'b0100, 4'b0000);
    tests_run++; if (bus.pending !== 4'b0100) begin tests_failed++; $display("FAIL trip_pending got=%b exp=0100", bus.pending); end
    tests_run++; if (bus.motor_up !== 1'b0) begin tests_failed++; $display("FAIL trip_motor_early got=%b exp=0", bus.motor_up); end
    @(negedge clk);
    tests_run++; if (bus.motor_up !== 1'b1) begin tests_failed++; $display("FAIL trip_motor_up got=%b exp=1", bus.motor_up); end
    set_sns(4'b0000);
    tests_run++; if (bus.motor_up !== 1'b1) begin tests_failed++; $display("FAIL trip_gap_motor got=%b exp=1", bus.motor_up); end
    set_sns(4'b0010);
    tests_run++; if (bus.motor_up !== 1'b1 || bus.story !== 3'd2) begin tests_failed++; $display("FAIL trip_pass_fl2 got=%b/%0d exp=1/2", bus.motor_up, bus.story); end
    set_sns(4'b0100);
    tests_run++; if (bus.motor_up !== 1'b0 || bus.door_open !== 1'b1) begin tests_failed++; $display("FAIL trip_arrive got=up%b door%b exp=up0 door1", bus.motor_up, bus.door_open); end
    tests_run++; if (bus.pending !== 4'b0000 || bus.story !== 3'd3) begin tests_failed++; $display("FAIL trip_arrive_pend got=%b/%0d exp=0000/3", bus.pending, bus.story); end
    run_ticks(47);
    tests_run++; if (bus.door_open !== 1'b1) begin tests_failed++; $display("FAIL trip_door_47 got=%b exp=1", bus.door_open); end
    run_ticks(1);
    tests_run++; if (bus.door_open !== 1'b0 || bus.state_dbg !== S_IDLE) begin tests_failed++; $display("FAIL trip_door_48 got=%b/%0d exp=0/%0d", bus.door_open, bus.state_dbg, S_IDLE); end
  endtask

  task automatic test_scan_order;
    do_reset(4'b0010);
    pulse_req(4'b1000, 4'b0000);
    @(negedge clk);
    tests_run++; if (bus.motor_up !== 1'b1) begin tests_failed++; $display("FAIL scan_depart got=%b exp=1", bus.motor_up); end
    bus.sns = 4'b0000;
    pulse_req(4'b0000, 4'b0001);
    tests_run++; if (bus.pending !== 4'b1001 || bus.motor_up !== 1'b1) begin tests_failed++; $display("FAIL scan_midreq got=%b/%b exp=1001/1", bus.pending, bus.motor_up); end
    set_sns(4'b0100);
    tests_run++; if (bus.motor_up !== 1'b1 || bus.door_open !== 1'b0) begin tests_failed++; $display("FAIL scan_pass_fl3 got=up%b door%b exp=up1 door0", bus.motor_up, bus.door_open); end
    set_sns(4'b1000);
    tests_run++; if (bus.door_open !== 1'b1 || bus.story !== 3'd4 || bus.pending !== 4'b0001) begin tests_failed++; $display("FAIL scan_fl4 got=door%b st%0d p%b exp=door1 st4 p0001", bus.door_open, bus.story, bus.pending); end
    run_ticks(48);
    tests_run++; if (bus.state_dbg !== S_IDLE || bus.door_open !== 1'b0) begin tests_failed++; $display("FAIL scan_idle got=%0d/%b exp=%0d/0", bus.state_dbg, bus.door_open, S_IDLE); end
    @(negedge clk);
    tests_run++; if (bus.state_dbg !== S_DN || bus.motor_dn !== 1'b1 || bus.motor_up !== 1'b0) begin tests_failed++; $display("FAIL scan_turn got=%0d dn%b up%b exp=%0d dn1 up0", bus.state_dbg, bus.motor_dn, bus.motor_up, S_DN); end
    set_sns(4'b0100);
    set_sns(4'b0010);
    tests_run++; if (bus.motor_dn !== 1'b1 || bus.story !== 3'd2) begin tests_failed++; $display("FAIL scan_down_pass got=%b/%0d exp=1/2", bus.motor_dn, bus.story); end
    set_sns(4'b0001);
    tests_run++; if (bus.door_open !== 1'b1 || bus.motor_dn !== 1'b0 || bus.story !== 3'd1 || bus.pending !== 4'b0000) begin tests_failed++; $display("FAIL scan_fl1 got=door%b dn%b st%0d p%b exp=door1 dn0 st1 p0000", bus.door_open, bus.motor_dn, bus.story, bus.pending); end
    run_ticks(48);
    tests_run++; if (bus.door_open !== 1'b0) begin tests_failed++; $display("FAIL scan_fl1_close got=%b exp=0", bus.door_open); end
  endtask

  task automatic test_door_restart;
    do_reset(4'b0100);
    pulse_req(4'b0100, 4'b0000);
    tests_run++; if (bus.pending !== 4'b0100) begin tests_failed++; $display("FAIL restart_latch got=%b exp=0100", bus.pending); end
    @(negedge clk);
    tests_run++; if (bus.door_open !== 1'b1 || bus.pending !== 4'b0000) begin tests_failed++; $display("FAIL restart_open got=%b/%b exp=1/0000", bus.door_open, bus.pending); end
    run_ticks(40);
    pulse_req(4'b0100, 4'b0000);
    tests_run++; if (bus.pending !== 4'b0000 || bus.door_open !== 1'b1) begin tests_failed++; $display("FAIL restart_press got=%b/%b exp=0000/1", bus.pending, bus.door_open); end
    run_ticks(47);
    tests_run++; if (bus.door_open !== 1'b1) begin tests_failed++; $display("FAIL restart_47 got=%b exp=1", bus.door_open); end
    run_ticks(1);
    tests_run++; if (bus.door_open !== 1'b0 || bus.pending !== 4'b0000) begin tests_failed++; $display("FAIL restart_48 got=%b/%b exp=0/0000", bus.door_open, bus.pending); end
  endtask

  task automatic test_simultaneous_and_reset;
    do_reset(4'b0010);
    pulse_req(4'b1001, 4'b0000);
    tests_run++; if (bus.pending !== 4'b1001) begin tests_failed++; $display("FAIL simul_pending got=%b exp=1001", bus.pending); end
    @(negedge clk);
    tests_run++; if (bus.motor_up !== 1'b1 || bus.motor_dn !== 1'b0) begin tests_failed++; $display("FAIL simul_dir got=up%b dn%b exp=up1 dn0", bus.motor_up, bus.motor_dn); end
    set_sns(4'b0100);
    set_sns(4'b1000);
    tests_run++; if (bus.door_open !== 1'b1 || bus.story !== 3'd4 || bus.pending !== 4'b0001) begin tests_failed++; $display("FAIL simul_fl4_first got=door%b st%0d p%b exp=door1 st4 p0001", bus.door_open, bus.story, bus.pending); end
    run_ticks(48);
    @(negedge clk);
    tests_run++; if (bus.motor_dn !== 1'b1) begin tests_failed++; $display("FAIL simul_then_down got=%b exp=1", bus.motor_dn); end
    pulse_req(4'b0000, 4'b1000);
    tests_run++; if (bus.pending !== 4'b1001 || bus.motor_dn !== 1'b1) begin tests_failed++; $display("FAIL prereset got=%b/%b exp=1001/1", bus.pending, bus.motor_dn); end
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++; if (bus.motor_dn !== 1'b0 || bus.pending !== 4'b0000 || bus.story !== 3'd1) begin tests_failed++; $display("FAIL async_reset got=dn%b p%b st%0d exp=dn0 p0000 st1", bus.motor_dn, bus.pending, bus.story); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    test_reset();
    test_single_trip();
    test_scan_order();
    test_door_restart();
    test_simultaneous_and_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
